// File: rtl/regfile_port_arbiter_if.sv
// Request/response channel between the two bank clients and regfile_port_arbiter.
// Requester-indexed vectors; per-requester address/data buses are suffixed 0/1.
interface regfile_port_arbiter_if #(
    parameter int N = 32,
    parameter int W = 8
);
    localparam int A = $clog2(N);

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_we;
    logic [A-1:0] req_addr_a0;
    logic [A-1:0] req_addr_a1;
    logic [A-1:0] req_addr_b0;
    logic [A-1:0] req_addr_b1;
    logic [W-1:0] req_wdata0;
    logic [W-1:0] req_wdata1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W-1:0] resp_rs1;
    logic [W-1:0] resp_rs2;

    modport master (
        output req_valid, req_we, req_addr_a0, req_addr_a1, req_addr_b0, req_addr_b1,
               req_wdata0, req_wdata1, resp_ready,
        input  req_ready, resp_valid, resp_rs1, resp_rs2
    );

    modport slave (
        input  req_valid, req_we, req_addr_a0, req_addr_a1, req_addr_b0, req_addr_b1,
               req_wdata0, req_wdata1, resp_ready,
        output req_ready, resp_valid, resp_rs1, resp_rs2
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Serialises two requesters' read-pair/write transactions onto one register-bank port.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module regfile_port_arbiter #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_arbiter_if.slave port,
    output logic [$clog2(N)-1:0]  rf_addr_rs1,
    output logic [$clog2(N)-1:0]  rf_addr_rs2,
    output logic [$clog2(N)-1:0]  rf_addr_rd,
    output logic                  rf_we,
    output logic [W-1:0]          rf_data_in,
    input  logic [W-1:0]          rf_rs1,
    input  logic [W-1:0]          rf_rs2
);
    localparam int A = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic         grant_s;
    logic         accept_s;
    logic         owner_r;
    logic         we_r;
    logic [A-1:0] addr_a_r;
    logic [A-1:0] addr_b_r;
    logic [W-1:0] wdata_r;
    logic [W-1:0] resp_rs1_r;
    logic [W-1:0] resp_rs2_r;

    assign accept_s      = (state_r == ST_IDLE) && (port.req_valid != 2'b00);
    assign port.resp_rs1 = resp_rs1_r;
    assign port.resp_rs2 = resp_rs2_r;

`ifdef ARB_FIXED_PRIO_EN
    // Winner select: requester 0 always takes precedence
    always_comb begin
        if (port.req_valid[0]) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
    end
`else
    logic ptr_r;

    // Winner select: tie goes to the pointer, a lone requester wins outright
    always_comb begin
        if (port.req_valid == 2'b11) begin
            grant_s = ptr_r;
        end else begin
            grant_s = port.req_valid[1];
        end
    end

    // Priority pointer moves to the other requester once a response is taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= 1'b0;
        end else if ((state_r == ST_RESP) && port.resp_ready[owner_r]) begin
            ptr_r <= ~owner_r;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_RESP;
            ST_RESP: begin
                if (port.resp_ready[owner_r]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Latched request and response data
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r    <= 1'b0;
            we_r       <= 1'b0;
            addr_a_r   <= {A{1'b0}};
            addr_b_r   <= {A{1'b0}};
            wdata_r    <= {W{1'b0}};
            resp_rs1_r <= {W{1'b0}};
            resp_rs2_r <= {W{1'b0}};
        end else begin
            if (accept_s) begin
                owner_r  <= grant_s;
                we_r     <= port.req_we[grant_s];
                addr_a_r <= grant_s ? port.req_addr_a1 : port.req_addr_a0;
                addr_b_r <= grant_s ? port.req_addr_b1 : port.req_addr_b0;
                wdata_r  <= grant_s ? port.req_wdata1 : port.req_wdata0;
            end
            if (state_r == ST_ISSUE) begin
                resp_rs1_r <= we_r ? {W{1'b0}} : rf_rs1;
                resp_rs2_r <= we_r ? {W{1'b0}} : rf_rs2;
            end
        end
    end

    // Output decode; rst gates accept and write so a reset cycle has no side effects
    always_comb begin
        port.req_ready  = 2'b00;
        port.resp_valid = 2'b00;
        rf_addr_rs1     = {A{1'b0}};
        rf_addr_rs2     = {A{1'b0}};
        rf_addr_rd      = {A{1'b0}};
        rf_we           = 1'b0;
        rf_data_in      = {W{1'b0}};
        if (accept_s && rst) begin
            port.req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            port.req_ready = 2'b00;
        end
        case (state_r)
            ST_ISSUE: begin
                rf_addr_rs1 = addr_a_r;
                rf_addr_rs2 = addr_b_r;
                if (we_r) begin
                    rf_addr_rd = addr_a_r;
                    rf_data_in = wdata_r;
                    rf_we      = rst && (addr_a_r != {A{1'b0}});
                end else begin
                    rf_addr_rd = {A{1'b0}};
                    rf_data_in = {W{1'b0}};
                    rf_we      = 1'b0;
                end
            end
            ST_RESP: port.resp_valid = owner_r ? 2'b10 : 2'b01;
            default: port.resp_valid = 2'b00;
        endcase
    end
endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Arbitrates single-port access to the W-bit, N-entry register bank between two independent requesters (0 and 1). It serialises each requester's read-pair or write transaction onto the bank's addr_rs1/addr_rs2/addr_rd/we/data_in port and returns the read data or a write acknowledge through a valid/ready response channel. It sits between the bank and its clients (e.g. a datapath sequencer and a debug/load port), so neither client drives the bank directly.

## Interface
- N, 32, number of bank entries; address width A = $clog2(N)
- W, 8, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid[1:0]  in  2  per-requester request valid
- req_ready[1:0]  out  2  per-requester accept strobe; at most one bit high
- req_we[1:0]  in  2  1 = write, 0 = read pair
- req_addr_a0/a1  in  A  read: rs1 address; write: destination address
- req_addr_b0/b1  in  A  read: rs2 address; ignored on write
- req_wdata0/1  in  W  write data
- resp_valid[1:0]  out  2  per-requester response valid; at most one bit high
- resp_ready[1:0]  in  2  per-requester response ready
- resp_rs1, resp_rs2  out  W each  read data (shared; qualified by resp_valid)
- rf_addr_rs1, rf_addr_rs2, rf_addr_rd  out  A each  to bank
- rf_we  out  1  to bank write enable
- rf_data_in  out  W  to bank write data
- rf_rs1, rf_rs2  in  W each  combinational bank read data

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if no req_valid, stay. Otherwise select winner (see Configuration), pulse req_ready[winner] combinationally in the same cycle, latch owner, we, addr_a, addr_b, wdata; go ISSUE. Loser's req_ready stays 0; it must hold its request.
- ISSUE (1 cycle): drive rf_addr_rs1=addr_a, rf_addr_rs2=addr_b. Write: rf_addr_rd=addr_a, rf_data_in=wdata, rf_we=1 unless addr_a==0 (rf_we=0, write dropped, still acknowledged). Read: rf_we=0; capture rf_rs1/rf_rs2 into resp_rs1/resp_rs2 at clock edge. Write: resp_rs1/resp_rs2 loaded with 0. Go RESP.
- RESP: resp_valid[owner]=1; hold resp data stable. On resp_ready[owner]=1: drop resp_valid, update priority pointer to the other requester, go IDLE. resp_ready of non-owner ignored.
- Outside ISSUE: rf_we=0, rf_addr_rd=0, rf_data_in=0, rf_addr_rs1/rs2=0.
- Read of address 0 returns whatever the bank returns (0).

## Timing
- Reset (rst=0 at edge): state IDLE, req_ready=0, resp_valid=0, resp_rs1=resp_rs2=0, rf_we=0, all rf_* addresses/data 0, pointer=0, latched request cleared. Reset in ISSUE or RESP aborts transaction; a write in ISSUE during reset cycle is not performed (rf_we forced 0 while rst=0).
- Accept at cycle T (IDLE, req_ready pulse); bank access T+1; resp_valid high from T+2.
- Zero-wait resp_ready: next accept earliest at T+3; peak throughput 1 transaction / 3 cycles.
- resp_valid, once high, stays high with stable data until handshake.
- Simultaneous req_valid on both in IDLE: exactly one accepted per Configuration rule.
- New requests arriving during ISSUE/RESP are not accepted until IDLE.

## Configuration
- ARB_FIXED_PRIO_EN defined: requester 0 always wins when both valid; pointer unused (may starve requester 1).
- ARB_FIXED_PRIO_EN undefined (default): round-robin; pointer names preferred requester, toggles to the other after each completed response; sole valid requester always wins regardless of pointer.

## Test plan
- Write then read: req0 write addr 5 data 0xA5 -> rf_we=1, rf_addr_rd=5 at T+1, resp_valid[0] at T+2 with rs1=rs2=0; req0 read a=5,b=0 -> resp_rs1=0xA5, resp_rs2=0x00.
- Write to address 0: req1 write addr 0 data 0xFF -> rf_we stays 0, resp_valid[1] asserted; subsequent read of 0 returns 0x00.
- Contention, round-robin (macro off): both valid from reset, continuous -> grants 0,1,0,1; each response on the matching resp_valid bit. With ARB_FIXED_PRIO_EN: grants 0,0,0,...
- Response backpressure: hold resp_ready[0]=0 for 5 cycles after resp_valid[0] -> data stable, no new req_ready, state held; release -> IDLE next cycle.
- Reset mid-transaction: rst=0 during ISSUE of write addr 7 data 0x3C -> no rf_we pulse, all outputs 0 next cycle; later read of 7 returns prior value.
- Idle quiescence: no req_valid for 20 cycles -> rf_we=0, req_ready=0, resp_valid=0 throughout.
